// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter (+ ripple_carry_adder_8_bit)
// Purpose  : Time-shares one 8-bit ripple-carry adder among NREQ requesters.
//            The winner's operands are captured, the adder is given SETTLE
//            cycles, and the registered {carry, sum} is held until res_ack.
// Options  : `define ADDARB_ROUND_ROBIN_EN selects round-robin arbitration;
//            otherwise fixed priority, with the lowest index winning.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] sum,
  output logic       c8
);
  logic r_unused;
  logic carry;

  // The carry is walked bit by bit so the chain mirrors a real ripple adder.
  always_comb begin
    carry = c0;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c8 = carry;
  end

  assign r_unused = 1'b0;
endmodule

module adder_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] op_a,
  input  logic [8*NREQ-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [7:0]        res_sum,
  output logic              res_carry,
  input  logic              res_ack
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_op_a;
  logic [7:0]      r_op_b;
  logic [3:0]      r_cnt;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [7:0]      w_win_a;
  logic [7:0]      w_win_b;
  logic [NREQ-1:0] w_onehot;
  logic [7:0]      w_sum;
  logic            w_c8;

`ifdef ADDARB_ROUND_ROBIN_EN
  logic [IDW-1:0]  r_ptr;
  int              w_dist;
  int              w_best;

  // Distance 0 is the requester just after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_dist  = 0;
    w_best  = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = (j + NREQ - 1 - int'(r_ptr)) % NREQ;
      if (req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_win   = IDW'(j);
        w_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_found = |req;
    w_win   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) w_win = IDW'(j);
    end
  end
`endif

  always_comb begin
    w_win_a = '0;
    w_win_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_win == IDW'(j)) begin
        w_win_a = op_a[8*j +: 8];
        w_win_b = op_b[8*j +: 8];
      end
    end
  end

  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

  // Only the captured operand registers ever reach the shared adder.
  ripple_carry_adder_8_bit u_adder (
    .a   (r_op_a),
    .b   (r_op_b),
    .c0  (1'b0),
    .sum (w_sum),
    .c8  (w_c8)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_cnt     <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
      res_carry <= 1'b0;
`ifdef ADDARB_ROUND_ROBIN_EN
      r_ptr     <= IDW'(NREQ - 1);
`endif
    end else begin
      case (r_state)
        IDLE: begin
          gnt <= '0;
          if (w_found) begin
            r_op_a  <= w_win_a;
            r_op_b  <= w_win_b;
            res_id  <= w_win;
            gnt     <= w_onehot;
            r_cnt   <= 4'(SETTLE);
            r_state <= BUSY;
`ifdef ADDARB_ROUND_ROBIN_EN
            r_ptr   <= w_win;
`endif
          end
        end
        BUSY: begin
          gnt   <= '0;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            res_sum   <= w_sum;
            res_carry <= w_c8;
            res_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// Module   : tb_adder_share_arbiter
// Purpose  : Directed and randomized checks of adder_share_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req;
  logic [8*NREQ-1:0] op_a, op_b;
  logic res_ack;
  logic [NREQ-1:0] gnt;
  logic res_valid;
  logic [IDW-1:0] res_id;
  logic [7:0] res_sum;
  logic res_carry;

  // Extra instances for the settle-time extremes.
  logic [NREQ-1:0] req1, req15, gnt1, gnt15;
  logic [8*NREQ-1:0] s_a, s_b;
  logic s_ack;
  logic v1, v15, c1, c15;
  logic [IDW-1:0] id1, id15;
  logic [7:0] sum1, sum15;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .res_carry(res_carry), .res_ack(res_ack));

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .req(req1), .op_a(s_a), .op_b(s_b), .gnt(gnt1),
    .res_valid(v1), .res_id(id1), .res_sum(sum1), .res_carry(c1),
    .res_ack(s_ack));

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(15)) dut_s15 (
    .clk(clk), .rst(rst), .req(req15), .op_a(s_a), .op_b(s_b), .gnt(gnt15),
    .res_valid(v15), .res_id(id15), .res_sum(sum15), .res_carry(c15),
    .res_ack(s_ack));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [NREQ-1:0] m_gnt;
  logic m_valid;
  logic [IDW-1:0] m_id;
  logic [7:0] m_sum, m_nsum;
  logic m_carry, m_ncarry;
  bit m_pending;
  int m_left;
  int m_last;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef ADDARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    logic [8:0] full;
    logic [NREQ-1:0] one;
    one = 1;
    if (rst) begin
      m_gnt = '0; m_valid = 1'b0; m_id = '0; m_sum = '0; m_carry = 1'b0;
      m_pending = 1'b0; m_left = 0; m_last = NREQ - 1;
    end else if (m_valid) begin
      m_gnt = '0;
      if (res_ack) m_valid = 1'b0;
    end else if (m_pending) begin
      m_gnt = '0;
      m_left--;
      if (m_left == 0) begin
        m_pending = 1'b0;
        m_valid = 1'b1;
        m_sum = m_nsum;
        m_carry = m_ncarry;
      end
    end else begin
      w = pick(req, m_last);
      if (w >= 0) begin
        full = 9'(op_a[8*w +: 8]) + 9'(op_b[8*w +: 8]);
        m_nsum = full[7:0];
        m_ncarry = full[8];
        m_gnt = one << w;
        m_id = IDW'(w);
        m_last = w;
        m_pending = 1'b1;
        m_left = SETTLE;
      end else begin
        m_gnt = '0;
      end
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("res_valid", 32'(res_valid), 32'(m_valid));
      if (m_valid) begin
        check("res_id", 32'(res_id), 32'(m_id));
        check("res_sum", 32'(res_sum), 32'(m_sum));
        check("res_carry", 32'(res_carry), 32'(m_carry));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 40 && !res_valid; k++) tick();
    check({name, "_timeout"}, 32'(res_valid), 32'd1);
  endtask

  task automatic run_one(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec, input string name);
    op_a[8*r +: 8] = a;
    op_b[8*r +: 8] = b;
    req = '0;
    req[r] = 1'b1;
    for (int k = 0; k < 10 && !gnt[r]; k++) tick();
    req = '0;
    wait_valid(name);
    check({name, "_id"}, 32'(res_id), r);
    check({name, "_sum"}, 32'(res_sum), 32'(es));
    check({name, "_carry"}, 32'(res_carry), 32'(ec));
    tick();
  endtask

  initial begin
    int t1, t15;
    logic [7:0] ss1, ss15, saved_sum;
    logic cc1, cc15;
    logic [IDW-1:0] saved_id;
    int ids[$];
    logic [NREQ-1:0] dropped;

    rst = 1'b1; req = '0; op_a = '0; op_b = '0; res_ack = 1'b0;
    req1 = '0; req15 = '0; s_a = 32'h0000_0055; s_b = 32'h0000_00AA; s_ack = 1'b0;
    repeat (3) tick();
    check("reset_gnt", 32'(gnt), 0);
    check("reset_valid", 32'(res_valid), 0);
    check("reset_id", 32'(res_id), 0);
    check("reset_sum", 32'(res_sum), 0);
    check("reset_carry", 32'(res_carry), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Settle extremes: 0x55 + 0xAA on both side instances.
    t1 = -1; t15 = -1; ss1 = '0; ss15 = '0; cc1 = 1'b1; cc15 = 1'b1;
    req1 = 4'b0001; req15 = 4'b0001;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (gnt1[0]) req1 = '0;
      if (gnt15[0]) req15 = '0;
      if (v1 && t1 < 0) begin t1 = c; ss1 = sum1; cc1 = c1; end
      if (v15 && t15 < 0) begin t15 = c; ss15 = sum15; cc15 = c15; end
    end
    check("settle1_cycle", t1, 2);
    check("settle1_sum", 32'(ss1), 32'hFF);
    check("settle1_carry", 32'(cc1), 0);
    check("settle15_cycle", t15, 16);
    check("settle15_sum", 32'(ss15), 32'hFF);
    check("settle15_carry", 32'(cc15), 0);

    // Single request with exact cycle timing.
    res_ack = 1'b1;
    op_a[23:16] = 8'h7F; op_b[23:16] = 8'h01; req = 4'b0100;
    tick();
    check("single_gnt_c1", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    check("single_valid_c2", 32'(res_valid), 0);
    tick();
    check("single_valid_c3", 32'(res_valid), 1);
    check("single_id", 32'(res_id), 2);
    check("single_sum", 32'(res_sum), 32'h80);
    check("single_carry", 32'(res_carry), 0);
    tick();

    run_one(0, 8'hFF, 8'h01, 8'h00, 1'b1, "ovf_ff_01");
    run_one(0, 8'hFF, 8'hFF, 8'hFE, 1'b1, "ovf_ff_ff");

    // Contention: everyone requests, drops for one cycle after its grant.
    rst = 1'b1; tick(); rst = 1'b0;
    op_a = 32'h4433_2211; op_b = 32'h0101_0101;
    req = 4'b1111; dropped = '0;
    for (int c = 0; c < 60 && ids.size() < 4; c++) begin
      tick();
      req = req | dropped;
      dropped = gnt;
      req = req & ~gnt;
      if (res_valid) ids.push_back(int'(res_id));
    end
    check("contend_count", ids.size(), 4);
    for (int k = 0; k < 4 && k < ids.size(); k++) begin
`ifdef ADDARB_ROUND_ROBIN_EN
      check("contend_rr_id", ids[k], k);
`else
      check("contend_fixed_id", ids[k], 0);
`endif
    end
    req = '0;
    repeat (6) tick();

    // Backpressure: hold the result for five cycles under full request load.
    res_ack = 1'b0;
    op_a = 32'h0403_0201; op_b = 32'h1010_1010;
    req = 4'b1111;
    wait_valid("bp");
    saved_sum = res_sum; saved_id = res_id;
    repeat (5) begin
      tick();
      check("bp_valid_hold", 32'(res_valid), 1);
      check("bp_sum_hold", 32'(res_sum), 32'(saved_sum));
      check("bp_id_hold", 32'(res_id), 32'(saved_id));
      check("bp_no_gnt", 32'(gnt), 0);
    end
    res_ack = 1'b1;
    tick();
    check("bp_valid_drop", 32'(res_valid), 0);
    check("bp_gnt_gap", 32'(gnt), 0);
    res_ack = 1'b0;
    tick();
    check("bp_next_gnt", 32'(|gnt), 1);
    req = '0; res_ack = 1'b1;
    repeat (6) tick();

    // Reset in the second BUSY cycle discards the operation.
    op_a[15:8] = 8'h10; op_b[15:8] = 8'h20; req = 4'b0010;
    tick();
    check("rst_mid_gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_gnt0", 32'(gnt), 0);
    check("rst_mid_valid0", 32'(res_valid), 0);
    check("rst_mid_sum0", 32'(res_sum), 0);
    rst = 1'b0;
    repeat (6) begin
      tick();
      check("rst_aborted_no_valid", 32'(res_valid), 0);
    end
    run_one(1, 8'h10, 8'h20, 8'h30, 1'b0, "after_rst");

    // Randomized traffic; idle requesters churn their operands freely.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          op_a[8*i +: 8] = 8'($urandom);
          op_b[8*i +: 8] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
      res_ack = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; req = '0; res_ack = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Time-shares one `ripple_carry_adder_8_bit` instance among NREQ requesters.
- Arbitrates among requesters and captures the winner's operands.
- Waits a fixed settle time for the carry ripple, then registers {carry, sum} with the winner's ID.
- Holds the result until the consumer acknowledges it.
- Sits between operand producers and the shared adder; it is the only driver of the adder's A/B inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.
- SETTLE, 2, clock cycles allowed for the adder to settle after operand capture (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  level request, bit i from requester i.
- op_a  input  8*NREQ  operand A; requester i drives bits [8i+7:8i].
- op_b  input  8*NREQ  operand B; same packing as op_a.
- gnt  output  NREQ  one-hot, one-cycle pulse: the requester's operands have been captured.
- res_valid  output  1  result available.
- res_id  output  IDW  index of the requester that owns the result.
- res_sum  output  8  sum bits from the adder.
- res_carry  output  1  carry-out (c8) from the adder.
- res_ack  input  1  consumer accepts result; only meaningful while res_valid=1.

Behaviour:
- Reset values:
  - state=IDLE, gnt=0, res_valid=0, res_id=0, res_sum=0x00, res_carry=0.
  - Operand registers = 0.
  - Round-robin pointer = NREQ-1, so req[0] has highest priority first.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req!=0, pick a winner w, latch op_a[w]/op_b[w] into the operand registers, latch w into the id register.
  - Drive gnt[w]=1 in the following cycle; load settle counter=SETTLE; go to BUSY.
  - If req==0, stay in IDLE; gnt=0.
- BUSY:
  - gnt is 0 except in the first BUSY cycle.
  - Counter decrements each cycle.
  - On the edge where counter==1: capture adder Sum into res_sum and c8 into res_carry, set res_valid=1, go to DONE.
- DONE:
  - Outputs held stable.
  - On the edge where res_ack=1: res_valid=0, go to IDLE.
  - No arbitration in the same cycle as ack; the next grant comes at the earliest one cycle later.
- Latency:
  - req seen in IDLE at cycle 0 -> gnt at cycle 1 -> res_valid at cycle SETTLE+1.
  - Default: res_valid at cycle 3.
  - Minimum cycles per transaction is SETTLE+2, plus ack wait.
- Adder feed: A/B come only from the operand registers, never combinationally from op_a/op_b.
- Width rules: the 9-bit true result is {res_carry, res_sum}. Wrap-around of res_sum on overflow is expected, with res_carry=1.
- Requester handshake:
  - Hold req and operands until gnt is seen.
  - Drop req on the cycle after gnt, or it is treated as a new request at the next IDLE.
- Boundary conditions:
  - req changes or drops during BUSY/DONE: ignored; the captured operation completes.
  - Operand changes after capture have no effect on the result.
  - res_ack while res_valid=0: ignored.
  - res_ack held high continuously: each result is valid for exactly one cycle.
  - Simultaneous requests: exactly one grant; winner chosen per the arbitration rule below.
  - rst asserted in any state: return to reset values next edge; any in-flight operation is discarded with no gnt/res_valid emitted.
  - req bits at index >= NREQ do not exist; res_id never exceeds NREQ-1.

Optional Feature:
- Macro ADDARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration; search begins at (last winner + 1) mod NREQ.
  - The pointer updates to the winner on each grant.
  - A requester holding req waits at most NREQ-1 transactions.
- Undefined:
  - Fixed priority; lowest index wins.
  - Pointer logic is absent from the netlist.

Test Plan:
- Single request: req=0100, op_a[2]=0x7F, op_b[2]=0x01 at cycle 0, res_ack=1 -> gnt=0100 at cycle 1; at cycle 3 res_valid=1, res_id=2, res_sum=0x80, res_carry=0.
- Overflow: req=0001, 0xFF+0x01 -> res_sum=0x00, res_carry=1. Also 0xFF+0xFF -> res_sum=0xFE, res_carry=1.
- Contention: req=1111 held, each requester drops req after its gnt then re-raises:
  - With ADDARB_ROUND_ROBIN_EN: res_id sequence is 0,1,2,3.
  - Without it, with req[0] re-raised: res_id is 0 repeatedly.
- Backpressure: res_ack=0 for 5 cycles after res_valid -> res_valid, res_sum, res_id stable; no gnt while req=1111. Then res_ack=1 for one cycle -> res_valid=0 next cycle; next gnt follows one cycle later.
- Reset mid-operation: rst=1 in the second BUSY cycle -> next cycle gnt=0, res_valid=0, res_sum=0x00. The aborted operation never produces res_valid; a new request after reset completes normally with correct sum.
- Settle parameter: SETTLE=1 and SETTLE=15 with 0x55+0xAA -> res_valid at cycles 2 and 16 respectively, res_sum=0xFF, res_carry=0.
